// File: rtl/timer_sample_scheduler.sv
// Drives the interval timer's Avalon-MM slave, turns each serviced timeout into a tick,
// and divides ticks into per-channel sample requests. Optional overrun logic: SCHED_OVERRUN_EN.
module timer_sample_scheduler #(
  parameter int          NUM_CH = 4,
  parameter logic [31:0] PERIOD = 32'd50000,
  parameter int          DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [2:0]              tmr_address,
  output logic [15:0]             tmr_writedata,
  input  logic                    tmr_irq,
  output logic [NUM_CH-1:0]       sample_req,
  input  logic [NUM_CH-1:0]       sample_ack,
  output logic [15:0]             tick_count,
  input  logic                    ovr_clr,
  output logic [NUM_CH-1:0]       overrun
);

  localparam logic [31:0] PERIOD_M1 = PERIOD - 32'd1;

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STOP, STOP_CLR
  } state_t;

  state_t state, next_state;

  logic              nxt_cs;
  logic [2:0]        nxt_addr;
  logic [15:0]       nxt_data;
  logic              tick;
  logic              load;
  logic [NUM_CH-1:0] event_v;

  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cfg_div [NUM_CH];
  logic [DIV_W-1:0]  cfg_cnt [NUM_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Bus fields are decoded from the next state so they leave flops aligned with the state.
  always_comb begin
    next_state = state;
    nxt_cs     = 1'b0;
    nxt_addr   = 3'd0;
    nxt_data   = 16'h0000;
    case (state)
      IDLE:     if (enable) next_state = WR_PL;
      WR_PL:    next_state = WR_PH;
      WR_PH:    next_state = WR_CTRL;
      WR_CTRL:  next_state = RUN;
      RUN: begin
        if (!enable)     next_state = STOP;
        else if (tmr_irq) next_state = CLR;
      end
      CLR:      next_state = RUN;
      STOP:     next_state = STOP_CLR;
      STOP_CLR: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    case (next_state)
      WR_PL: begin
        nxt_cs = 1'b1; nxt_addr = 3'd2; nxt_data = PERIOD_M1[15:0];
      end
      WR_PH: begin
        nxt_cs = 1'b1; nxt_addr = 3'd3; nxt_data = PERIOD_M1[31:16];
      end
      WR_CTRL: begin
        nxt_cs = 1'b1; nxt_addr = 3'd1; nxt_data = 16'h0007;
      end
      STOP: begin
        nxt_cs = 1'b1; nxt_addr = 3'd1; nxt_data = 16'h0008;
      end
      CLR, STOP_CLR: begin
        nxt_cs = 1'b1; nxt_addr = 3'd0; nxt_data = 16'h0000;
      end
      default: begin
        nxt_cs = 1'b0; nxt_addr = 3'd0; nxt_data = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0000;
    end else begin
      tmr_chipselect <= nxt_cs;
      tmr_write_n    <= ~nxt_cs;
      tmr_address    <= nxt_addr;
      tmr_writedata  <= nxt_data;
    end
  end

  assign tick = (state == CLR);
  assign load = (state == WR_CTRL);

  always_comb begin
    event_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_div[i] = div_cfg[i*DIV_W +: DIV_W];
      cfg_cnt[i] = (cfg_div[i] == '0) ? '0 : cfg_div[i] - DIV_W'(1);
      event_v[i] = tick && (div_q[i] != '0) && (cnt_q[i] == '0);
    end
  end

  // Divider settings are captured at start so mid-run div_cfg edits wait for the next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load) begin
          div_q[i] <= cfg_div[i];
          cnt_q[i] <= cfg_cnt[i];
        end else if (tick && div_q[i] != '0) begin
          if (cnt_q[i] == '0) cnt_q[i] <= div_q[i] - DIV_W'(1);
          else                cnt_q[i] <= cnt_q[i] - DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= 16'h0000;
      sample_req <= '0;
    end else begin
      if (load)      tick_count <= 16'h0000;
      else if (tick) tick_count <= tick_count + 16'h0001;
      sample_req <= event_v | (sample_req & ~sample_ack);
    end
  end

`ifdef SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q;

  // A new set in the same cycle as ovr_clr survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overrun_q <= '0;
    else          overrun_q <= (event_v & sample_req & ~sample_ack) | (ovr_clr ? '0 : overrun_q);
  end

  assign overrun = overrun_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = '0;
`endif

endmodule

// File: tb/tb_timer_sample_scheduler.sv
// Bench for timer_sample_scheduler: behavioural timer, scripted bus-op reference model,
// directed literal checks followed by randomized operation.
module tb_timer_sample_scheduler;

  localparam int          NCH = 4;
  localparam int          DW  = 8;
  localparam logic [31:0] PER = 32'd20;
`ifdef SCHED_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  localparam int K_NONE = 0, K_CFG = 1, K_CTRL = 2, K_TICK = 3, K_END = 4, K_OTHER = 5;

  typedef struct {
    bit        cs;
    bit [2:0]  a;
    bit [15:0] d;
    int        kind;
  } op_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [NCH*DW-1:0] div_cfg;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [2:0]        tmr_address;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;
  logic [NCH-1:0]    sample_req;
  logic [NCH-1:0]    sample_ack;
  logic [15:0]       tick_count;
  logic              ovr_clr;
  logic [NCH-1:0]    overrun;

  timer_sample_scheduler #(.NUM_CH(NCH), .PERIOD(PER), .DIV_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .div_cfg(div_cfg),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_address(tmr_address), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
    .sample_req(sample_req), .sample_ack(sample_ack), .tick_count(tick_count),
    .ovr_clr(ovr_clr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural interval timer answering the DUT's bus writes.
  logic        t_run, t_to, t_ito, inj;
  logic [31:0] t_cnt, t_per;
  assign tmr_irq = (t_to & t_ito) | inj;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cnt <= '0; t_per <= '0;
    end else begin
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= tmr_writedata[0];
            if (tmr_writedata[3]) t_run <= 1'b0;
            else if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= '0; end
          end
          3'd2: t_per[15:0]  <= tmr_writedata;
          3'd3: t_per[31:16] <= tmr_writedata;
          default: ;
        endcase
      end
      if (t_run && !(tmr_chipselect && !tmr_write_n && tmr_address == 3'd1)) begin
        if (t_cnt == t_per) begin t_cnt <= '0; t_to <= 1'b1; end
        else t_cnt <= t_cnt + 1;
      end
    end
  end

  // Reference model: a script of expected bus operations plus tick/divider arithmetic.
  function automatic op_t mk(input bit cs, input bit [2:0] a, input bit [15:0] d, input int k);
    op_t o;
    o.cs = cs; o.a = a; o.d = d; o.kind = k;
    return o;
  endfunction

  op_t      cur;
  op_t      q[$];
  bit       m_run;
  int       m_ticks;
  int       m_div[NCH];
  bit [3:0] m_req, m_ovr, m_ev;
  logic [31:0] pm1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur = mk(0, 0, 0, K_NONE); q.delete(); m_run = 0; m_ticks = 0;
      m_req = 0; m_ovr = 0;
      for (int i = 0; i < NCH; i++) m_div[i] = 0;
    end else begin
      m_ev = 0;
      if (cur.kind == K_CTRL) begin
        m_ticks = 0; m_run = 1;
        for (int i = 0; i < NCH; i++) m_div[i] = int'(div_cfg[i*DW +: DW]);
      end
      if (cur.kind == K_TICK) begin
        m_ticks++;
        for (int i = 0; i < NCH; i++)
          if (m_div[i] != 0 && (m_ticks % m_div[i]) == 0) m_ev[i] = 1'b1;
      end
      if (cur.kind == K_END) m_run = 0;
      if (OVR_EN) m_ovr = (m_ev & m_req & ~sample_ack) | (ovr_clr ? 4'b0 : m_ovr);
      m_req = m_ev | (m_req & ~sample_ack);
      pm1 = PER - 1;
      if (q.size() != 0) cur = q.pop_front();
      else if (cur.cs) cur = mk(0, 0, 0, K_NONE);
      else if (!m_run) begin
        if (enable) begin
          q.push_back(mk(1, 2, pm1[15:0], K_CFG));
          q.push_back(mk(1, 3, pm1[31:16], K_CFG));
          q.push_back(mk(1, 1, 16'h0007, K_CTRL));
          cur = q.pop_front();
        end
      end else if (!enable) begin
        q.push_back(mk(1, 1, 16'h0008, K_OTHER));
        q.push_back(mk(1, 0, 16'h0000, K_END));
        cur = q.pop_front();
      end else if (tmr_irq) cur = mk(1, 0, 16'h0000, K_TICK);
    end
  end

  int       pulses[NCH];
  bit [3:0] prev_req = 0;

  always @(negedge clk) begin
    chk("bus_cs", 32'(tmr_chipselect), 32'(cur.cs));
    chk("bus_write_n", 32'(tmr_write_n), 32'(!cur.cs));
    chk("bus_addr", 32'(tmr_address), 32'(cur.a));
    chk("bus_data", 32'(tmr_writedata), 32'(cur.d));
    chk("tick_count", 32'(tick_count), 32'(m_ticks[15:0]));
    chk("sample_req", 32'(sample_req), 32'(m_req));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    for (int i = 0; i < NCH; i++)
      if (sample_req[i] && !prev_req[i]) pulses[i]++;
    prev_req = sample_req;
  end

  // 0: random ack, 1: withhold, 2: ack only during a status-clear write, 3: ack whenever req
  int ack_mode[NCH];
  bit rnd = 0;

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      case (ack_mode[i])
        0:       sample_ack[i] = 1'($urandom % 2);
        1:       sample_ack[i] = 1'b0;
        2:       sample_ack[i] = tmr_chipselect && !tmr_write_n && tmr_address == 3'd0;
        default: sample_ack[i] = sample_req[i];
      endcase
    end
    if (rnd) begin
      if ($urandom_range(0, 99) == 0) enable = !enable;
      for (int i = 0; i < NCH; i++) div_cfg[i*DW +: DW] = DW'($urandom_range(0, 3));
      ovr_clr = ($urandom_range(0, 15) == 0);
      inj     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end else begin
      ovr_clr = 1'b0;
      inj     = 1'b0;
    end
  endtask

  task automatic chk_bus(input string n, input bit cs, input bit [2:0] a, input bit [15:0] d);
    chk({n, "_cs"}, 32'(tmr_chipselect), 32'(cs));
    chk({n, "_addr"}, 32'(tmr_address), 32'(a));
    chk({n, "_data"}, 32'(tmr_writedata), 32'(d));
  endtask

  task automatic wait_tick(input int target, input int bound);
    int n = 0;
    while (int'(tick_count) != target && n < bound) begin
      cyc();
      n++;
    end
    chk("wait_tick", 32'(tick_count), 32'(target[15:0]));
  endtask

  task automatic chk_reset_outputs(input string n);
    chk_bus(n, 0, 0, 0);
    chk({n, "_write_n"}, 32'(tmr_write_n), 32'd1);
    chk({n, "_req"}, 32'(sample_req), 32'd0);
    chk({n, "_tick"}, 32'(tick_count), 32'd0);
    chk({n, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic start_seq(input string n);
    enable = 1'b1;
    cyc(); chk_bus({n, "_pl"}, 1, 2, 16'h0013);
    cyc(); chk_bus({n, "_ph"}, 1, 3, 16'h0000);
    cyc(); chk_bus({n, "_ctrl"}, 1, 1, 16'h0007);
    cyc(); chk_bus({n, "_run"}, 0, 0, 16'h0000);
    chk({n, "_tick0"}, 32'(tick_count), 32'd0);
  endtask

  int base[NCH];
  int tc;

  initial begin
    reset_n = 1'b0; enable = 1'b0; div_cfg = '0; sample_ack = '0; ovr_clr = 1'b0; inj = 1'b0;
    for (int i = 0; i < NCH; i++) begin ack_mode[i] = 3; pulses[i] = 0; end
    repeat (3) cyc();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) cyc();

    // Dividers {ch3=3, ch2=0, ch1=2, ch0=1}, six ticks.
    div_cfg = 32'h0300_0201;
    for (int i = 0; i < NCH; i++) base[i] = pulses[i];
    start_seq("start");
    wait_tick(6, 400);
    enable = 1'b0;
    cyc(); chk_bus("stop", 1, 1, 16'h0008);
    cyc(); chk_bus("stop_clr", 1, 0, 16'h0000);
    cyc(); chk_bus("idle", 0, 0, 16'h0000);
    chk("ticks_after_stop", 32'(tick_count), 32'd6);
    repeat (3) cyc();
    chk("pulses_ch0", 32'(pulses[0] - base[0]), 32'd6);
    chk("pulses_ch1", 32'(pulses[1] - base[1]), 32'd3);
    chk("pulses_ch2", 32'(pulses[2] - base[2]), 32'd0);
    chk("pulses_ch3", 32'(pulses[3] - base[3]), 32'd2);

    // Restart with div=1 on ch0 and ack withheld for two ticks.
    div_cfg = 32'h0000_0001;
    ack_mode[0] = 1;
    start_seq("restart");
    wait_tick(2, 200);
    chk("ovr_req_held", 32'(sample_req[0]), 32'd1);
    chk("ovr_set", 32'(overrun[0]), 32'(OVR_EN));
    ack_mode[0] = 3;
    cyc(); cyc();
    chk("ack_clears_req", 32'(sample_req[0]), 32'd0);
    chk("ovr_sticky", 32'(overrun[0]), 32'(OVR_EN));
    ovr_clr = 1'b1;
    cyc(); cyc();
    chk("ovr_cleared", 32'(overrun), 32'd0);
    ack_mode[0] = 2;
    tc = int'(tick_count);
    wait_tick(tc + 2, 200);
    chk("same_cycle_req", 32'(sample_req[0]), 32'd1);
    chk("same_cycle_ovr", 32'(overrun[0]), 32'd0);

    // Asynchronous reset in the middle of RUN.
    cyc();
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    enable = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    for (int i = 0; i < NCH; i++) ack_mode[i] = 0;
    rnd = 1;
    repeat (3000) cyc();
    rnd = 0;
    enable = 1'b0;
    repeat (5) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
